mem_arbiter: RTL
================

# mem_arbiter

Two-master, one-slave arbiter that shares the core's single memory port between instruction fetch (IFU, master 0) and load/store (LSU, master 1). It grants fairly with round-robin, holds a grant until the slave accepts, and routes the slave's response back to the owning master. A response watchdog returns an error response so a hung slave cannot deadlock the core. It sits between IFU/LSU and the SRAM/bus bridge.

## Interface
- TIMEOUT, 255: maximum cycles to wait for a slave response after request acceptance; 0 disables the watchdog.
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake.
- ifu_addr  in  32  fetch address; fetches are always reads.
- ifu_resp_valid  out  1  IFU response strobe.
- ifu_rdata  out  32  fetched word.
- ifu_resp_err  out  1  error flag, set on watchdog timeout.
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake.
- lsu_addr  in  32  load/store address.
- lsu_wen  in  1  write enable.
- lsu_wdata  in  32  store data.
- lsu_wmask  in  4  byte mask.
- lsu_resp_valid / lsu_rdata / lsu_resp_err  out  1/32/1  LSU response.
- s_req_valid / s_req_ready  out / in  1  slave request handshake.
- s_addr, s_wen, s_wdata, s_wmask  out  32/1/32/4  forwarded request fields. For IFU: s_wen=0, s_wdata=0, s_wmask=0.
- s_resp_valid / s_rdata  in  1/32  slave response.

## Operation
- States: IDLE, HOLD, WAIT. Registers: owner (IFU/LSU), last_grant, watchdog counter.
- IDLE:
  - Winner is chosen combinationally. If only one master is valid, it wins. If both are valid, the master that is not last_grant wins.
  - s_req_valid is asserted when any master is valid. Slave request fields are driven from the winner.
  - Winner's ready = s_req_ready. Loser's ready = 0.
  - Handshake (s_req_valid & s_req_ready): owner := winner, last_grant := winner, counter := 0, next state WAIT.
  - Valid but not ready: owner := winner, next state HOLD.
- HOLD:
  - Slave request fields come from owner. Only the owner's ready can assert.
  - Grant is locked, so a newly valid competitor cannot steal it.
  - Handshake: last_grant := owner, counter := 0, next state WAIT.
- Master rule: once valid, a master holds valid and all fields stable until ready. HOLD relies on this.
- WAIT:
  - s_req_valid = 0. Both masters' ready = 0.
  - s_resp_valid is forwarded combinationally to the owner's resp_valid, with rdata = s_rdata and err = 0. Next state IDLE.
  - If no response: counter increments.
  - If TIMEOUT≠0 and counter == TIMEOUT with no response: owner gets resp_valid=1, err=1, rdata=0 that cycle. Next state IDLE.
- The non-owner never sees resp_valid.
- s_resp_valid in IDLE or HOLD is ignored and dropped, including late responses after a timeout.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- A response in the same cycle the watchdog fires takes priority: data is delivered with err=0.

## Timing
- Zero-cycle grant: a request is forwarded to the slave in the cycle it is valid.
- Response arrives at the earliest one cycle after acceptance. The response-to-master path is combinational.
- Back-to-back throughput is one transaction per 2 cycles with a 1-cycle slave (accept, then response; the next accept happens in the cycle after the response).
- Reset, async at any time including mid-WAIT:
  - Registers: state=IDLE, last_grant=LSU (so IFU wins the first tie), counter=0, owner=IFU.
  - While rst=1, all readies, s_req_valid, and both resp_valids are forced to 0; all data outputs are 0.
  - An in-flight transaction is abandoned and its response is dropped.
- Timeout response fires exactly TIMEOUT+1 cycles after the accept cycle.

## Structure
- arb_pkg:
  - state_e {ST_IDLE, ST_HOLD, ST_WAIT}
  - owner_e {OWN_IFU=0, OWN_LSU=1}
  - mem_req_t struct {addr, wen, wdata, wmask}
- Sub-module mem_req_mux selects the mem_req_t by owner/winner and zero-fills IFU write fields. The FSM, round-robin logic and watchdog stay in mem_arbiter.

## Test plan
- Both masters idle after reset, then simultaneous requests: ifu_addr=0x80000000, lsu_addr=0x80001000 (read), slave always ready with 1-cycle response.
  - IFU granted first and receives s_rdata.
  - LSU is accepted 2 cycles later; the two transactions alternate thereafter.
- Slave holds s_req_ready=0 for 3 cycles while IFU is valid; LSU raises valid in cycle 2.
  - Arbiter stays in HOLD on IFU and s_addr stays 0x80000000.
  - LSU is served next.
- LSU store: addr=0x80000010, wdata=0xDEADBEEF, wmask=0xF.
  - s_wen=1 with identical fields.
  - lsu_resp_valid=1, ifu_resp_valid=0.
- TIMEOUT=4, slave never responds.
  - Owner gets resp_valid=1, err=1, rdata=0 exactly 5 cycles after accept.
  - A slave response 2 cycles later is dropped.
- Slave responds in the same cycle the counter reaches TIMEOUT.
  - err=0 and data is delivered.
- rst asserted mid-WAIT with an LSU request outstanding.
  - All outputs go to 0 immediately.
  - After release the next tie goes to IFU and the stale response is ignored.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the IFU/LSU memory port arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_req_mux.sv
// rtl/mem_req_mux.sv - selects the slave request fields from IFU or LSU
// IFU fetches are reads, so its write fields are forced to zero.
module mem_req_mux
    import arb_pkg::*;
(
    input  owner_e      sel,
    input  logic [31:0] ifu_addr,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output mem_req_t    req
);

    always_comb begin
        req.addr  = ifu_addr;
        req.wen   = 1'b0;
        req.wdata = '0;
        req.wmask = '0;
        if (sel == OWN_LSU) begin
            req.addr  = lsu_addr;
            req.wen   = lsu_wen;
            req.wdata = lsu_wdata;
            req.wmask = lsu_wmask;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter for one memory slave
// Grant locks until the slave accepts; a watchdog answers hung responses.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        s_req_valid,
    input  logic        s_req_ready,
    output logic [31:0] s_addr,
    output logic        s_wen,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    input  logic        s_resp_valid,
    input  logic [31:0] s_rdata
);

    // A zero TIMEOUT still needs a one-bit counter to keep the types legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_e        state, state_n;
    owner_e        owner, owner_n;
    owner_e        last_grant, last_n;
    owner_e        winner, sel;
    logic [CW-1:0] cnt, cnt_n;
    logic          req_valid;
    logic          resp_fire;
    logic          resp_err;
    logic [31:0]   resp_data;
    mem_req_t      req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_n;
            cnt        <= cnt_n;
        end
    end

    // On a tie the master that did not win last time gets the port.
    always_comb begin
        winner = OWN_IFU;
        if (ifu_req_valid && lsu_req_valid) begin
            winner = (last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (lsu_req_valid) begin
            winner = OWN_LSU;
        end
    end

    assign sel = (state == ST_IDLE) ? winner : owner;

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        last_n    = last_grant;
        cnt_n     = cnt;
        req_valid = 1'b0;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        case (state)
            ST_IDLE: begin
                req_valid = ifu_req_valid || lsu_req_valid;
                if (req_valid) begin
                    owner_n = winner;
                    if (s_req_ready) begin
                        last_n  = winner;
                        cnt_n   = '0;
                        state_n = ST_WAIT;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                req_valid = 1'b1;
                if (s_req_ready) begin
                    last_n  = owner;
                    cnt_n   = '0;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real response beats the watchdog when both land together.
                if (s_resp_valid) begin
                    resp_fire = 1'b1;
                    resp_data = s_rdata;
                    state_n   = ST_IDLE;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LIMIT)) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_n   = ST_IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    mem_req_mux u_mem_req_mux (
        .sel       (sel),
        .ifu_addr  (ifu_addr),
        .lsu_addr  (lsu_addr),
        .lsu_wen   (lsu_wen),
        .lsu_wdata (lsu_wdata),
        .lsu_wmask (lsu_wmask),
        .req       (req)
    );

    assign s_req_valid   = !rst && req_valid;
    assign ifu_req_ready = !rst && req_valid && s_req_ready && (sel == OWN_IFU);
    assign lsu_req_ready = !rst && req_valid && s_req_ready && (sel == OWN_LSU);
    assign s_addr        = rst ? '0 : req.addr;
    assign s_wen         = !rst && req.wen;
    assign s_wdata       = rst ? '0 : req.wdata;
    assign s_wmask       = rst ? '0 : req.wmask;

    assign ifu_resp_valid = !rst && resp_fire && (owner == OWN_IFU);
    assign lsu_resp_valid = !rst && resp_fire && (owner == OWN_LSU);
    assign ifu_resp_err   = ifu_resp_valid && resp_err;
    assign lsu_resp_err   = lsu_resp_valid && resp_err;
    assign ifu_rdata      = ifu_resp_valid ? resp_data : '0;
    assign lsu_rdata      = lsu_resp_valid ? resp_data : '0;

endmodule
